// File: rtl/load_store_unit.sv
// Data-memory access stage: latches one load/store, runs a req/ready handshake, extends load data.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_sig,
  input  logic              load_store_sel,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] rv2,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              lsu_err
);

  // state  | meaning
  // IDLE   | waiting for dmem_sig; request latched on entry to ACCESS
  // ACCESS | mem_req held until mem_ready or wait counter expires
  // DONE   | single retire cycle; ld_valid or lsu_err pulse
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;

  logic              is_byte, is_half, is_unsigned;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_ext;
  logic [3:0]        we_calc;
  logic [DATA_W-1:0] wdata_calc;
  logic              misaligned;

  // Reserved funct3 encodings fall through to word size.
  assign is_byte     = (funct3_q[1:0] == 2'b00);
  assign is_half     = (funct3_q[1:0] == 2'b01);
  assign is_unsigned = funct3_q[2];

  always_comb begin
    rd_shift = '0;
    ld_ext   = mem_rdata;
    if (is_byte) begin
      rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
      ld_ext   = {{(DATA_W-8){~is_unsigned & rd_shift[7]}}, rd_shift[7:0]};
    end else if (is_half) begin
      rd_shift = mem_rdata >> {addr_q[1], 4'b0000};
      ld_ext   = {{(DATA_W-16){~is_unsigned & rd_shift[15]}}, rd_shift[15:0]};
    end
  end

  always_comb begin
    we_calc    = 4'b1111;
    wdata_calc = wdata_q;
    if (is_byte) begin
      we_calc    = 4'b0001 << addr_q[1:0];
      wdata_calc = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      we_calc    = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{wdata_q[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if (funct3[1:0] == 2'b01)
      misaligned = daddr[0];
    else if (funct3[1:0] != 2'b00)
      misaligned = (daddr[1:0] != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;
    case (state_q)
      IDLE: begin
        if (dmem_sig) begin
          addr_d   = daddr;
          wdata_d  = rv2;
          funct3_d = funct3;
          sel_d    = load_store_sel;
          cnt_d    = '0;
          if (misaligned) begin
            state_d   = DONE;
            err_d     = 1'b1;
            ld_data_d = '0;
          end else begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = DONE;
          if (!sel_q) ld_data_d = ld_ext;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = DONE;
          err_d     = 1'b1;
          ld_data_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign stall     = ((state_q == IDLE) & dmem_sig) | (state_q == ACCESS);
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = (mem_req & sel_q) ? we_calc : 4'b0000;
  assign mem_addr  = mem_req ? {addr_q[DATA_W-1:2], 2'b00} : '0;
  assign mem_wdata = (mem_req & sel_q) ? wdata_calc : '0;
  assign ld_valid  = (state_q == DONE) & ~sel_q & ~err_q;
  assign lsu_err   = (state_q == DONE) & err_q;
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; follows LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset, dmem_sig, load_store_sel, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] daddr, rv2, mem_rdata;
  logic        stall, ld_valid, mem_req, lsu_err;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  int total = 0;
  int bad   = 0;

  // Observations of the most recent run_op
  int          o_stall, o_acc;
  bit          o_done, o_valid, o_err, o_early, o_post_pulse;
  logic [3:0]  o_we;
  logic [31:0] o_addr, o_wdata, o_ld;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .dmem_sig(dmem_sig), .load_store_sel(load_store_sel),
    .funct3(funct3), .daddr(daddr), .rv2(rv2), .stall(stall), .ld_data(ld_data),
    .ld_valid(ld_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .lsu_err(lsu_err)
  );

  // Drives one instruction; ready_at = ACCESS cycle that sees mem_ready (0 = never).
  task automatic run_op(input logic sel, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ready_at);
    o_stall = 0; o_acc = 0; o_done = 0; o_valid = 0; o_err = 0; o_early = 0;
    o_post_pulse = 0; o_we = '0; o_addr = '0; o_wdata = '0; o_ld = '0;
    dmem_sig = 1'b1; load_store_sel = sel; funct3 = f3; daddr = a; rv2 = wd;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) begin
        o_done = 1; o_valid = ld_valid; o_err = lsu_err; o_ld = ld_data;
        dmem_sig = 1'b0; mem_ready = 1'b0;
        break;
      end
      o_stall++;
      if (ld_valid || lsu_err) o_early = 1;
      if (mem_req) begin
        o_acc++; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
        mem_ready = (o_acc == ready_at);
        mem_rdata = (o_acc == ready_at) ? rd : 32'h0;
      end
      @(negedge clk);
    end
    dmem_sig = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    o_post_pulse = ld_valid | lsu_err | stall;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; dmem_sig = 1'b0; load_store_sel = 1'b0; funct3 = 3'b0;
    daddr = '0; rv2 = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({stall, mem_req, ld_valid, lsu_err, mem_we} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000000", {stall, mem_req, ld_valid, lsu_err, mem_we});
    end
    total++;
    if (ld_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_data ld=%h addr=%h wd=%h want all 0", ld_data, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_sw();
    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    total++;
    if (o_we !== 4'b1111 || o_addr !== 32'h100 || o_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_port we=%b addr=%h wd=%h want 1111/00000100/deadbeef", o_we, o_addr, o_wdata);
    end
    total++;
    if (o_stall !== 3 || !o_done) begin
      bad++; $display("FAIL sw_stall got=%0d done=%0d want 3 done=1", o_stall, o_done);
    end
    total++;
    if (o_valid || o_err || o_early || o_post_pulse) begin
      bad++; $display("FAIL sw_flags valid=%0d err=%0d early=%0d post=%0d want 0", o_valid, o_err, o_early, o_post_pulse);
    end
  endtask

  task automatic test_store_narrow();
    run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
    total++;
    if (o_we !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 || o_addr !== 32'h100) begin
      bad++; $display("FAIL sb_port we=%b wd=%h addr=%h want 1000/a5a5a5a5/00000100", o_we, o_wdata, o_addr);
    end
    total++;
    if (o_stall !== 2) begin
      bad++; $display("FAIL sb_min_latency stall=%0d want 2", o_stall);
    end
    run_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
    total++;
    if (o_we !== 4'b1100 || o_wdata !== 32'hABCDABCD) begin
      bad++; $display("FAIL sh_port we=%b wd=%h want 1100/abcdabcd", o_we, o_wdata);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b101, 3'b001, 3'b010};
    logic [31:0] adrs [4] = '{32'h3, 32'h2, 32'h0, 32'h0};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00008000, 32'hFFFFF0FF, 32'h8000F0FF};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3s[i], adrs[i], 32'h0, 32'h8000F0FF, 1);
      total++;
      if (!o_valid || o_err || o_ld !== exps[i] || o_we !== 4'b0000) begin
        bad++; $display("FAIL load_%0d valid=%0d err=%0d ld=%h we=%b want 1/0/%h/0000", i, o_valid, o_err, o_ld, o_we, exps[i]);
      end
      total++;
      if (o_post_pulse || o_early) begin
        bad++; $display("FAIL load_pulse_%0d post=%0d early=%0d want 0", i, o_post_pulse, o_early);
      end
    end
    // store must not disturb held load data
    run_op(1'b1, 3'b010, 32'h200, 32'h55555555, 32'h0, 1);
    #1;
    total++;
    if (ld_data !== 32'h8000F0FF) begin
      bad++; $display("FAIL ld_data_hold got=%h want 8000f0ff", ld_data);
    end
  endtask

  task automatic test_ready_outside();
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (stall || mem_req || ld_valid || lsu_err || ld_data !== 32'h8000F0FF) begin
      bad++; $display("FAIL ready_idle st=%0d req=%0d v=%0d e=%0d ld=%h want idle/8000f0ff", stall, mem_req, ld_valid, lsu_err, ld_data);
    end
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0);
    total++;
    if (!o_done || o_stall !== 17 || o_acc !== 16) begin
      bad++; $display("FAIL timeout_len done=%0d stall=%0d acc=%0d want 1/17/16", o_done, o_stall, o_acc);
    end
    total++;
    if (!o_err || o_valid || o_ld !== 32'h0 || o_post_pulse) begin
      bad++; $display("FAIL timeout_flags err=%0d valid=%0d ld=%h post=%0d want 1/0/0/0", o_err, o_valid, o_ld, o_post_pulse);
    end
  endtask

  task automatic test_misaligned();
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (o_acc !== 0 || o_stall !== 1 || !o_err || o_valid || o_ld !== 32'h0) begin
      bad++; $display("FAIL misalign_trap acc=%0d stall=%0d err=%0d valid=%0d ld=%h want 0/1/1/0/0", o_acc, o_stall, o_err, o_valid, o_ld);
    end
`else
    total++;
    if (o_addr !== 32'h100 || !o_valid || o_err || o_ld !== 32'h11223344) begin
      bad++; $display("FAIL misalign_nocheck addr=%h valid=%0d err=%0d ld=%h want 00000100/1/0/11223344", o_addr, o_valid, o_err, o_ld);
    end
`endif
  endtask

  task automatic test_reset_mid();
    dmem_sig = 1'b1; load_store_sel = 1'b0; funct3 = 3'b010; daddr = 32'h400; mem_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if (!mem_req || !stall) begin
      bad++; $display("FAIL mid_access req=%0d stall=%0d want 1/1", mem_req, stall);
    end
    reset = 1'b1; dmem_sig = 1'b0;
    @(negedge clk); #1;
    total++;
    if (mem_req || stall || ld_data !== 32'h0 || lsu_err || ld_valid) begin
      bad++; $display("FAIL reset_mid req=%0d stall=%0d ld=%h err=%0d v=%0d want 0/0/0/0/0", mem_req, stall, ld_data, lsu_err, ld_valid);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 3'b100, 32'h501, 32'h0, 32'h0000C300, 1);
    total++;
    if (!o_valid || o_ld !== 32'h000000C3) begin
      bad++; $display("FAIL b2b_lbu valid=%0d ld=%h want 1/000000c3", o_valid, o_ld);
    end
    run_op(1'b0, 3'b000, 32'h501, 32'h0, 32'h0000C300, 3);
    total++;
    if (!o_valid || o_ld !== 32'hFFFFFFC3 || o_stall !== 4) begin
      bad++; $display("FAIL b2b_lb valid=%0d ld=%h stall=%0d want 1/ffffffc3/4", o_valid, o_ld, o_stall);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store_sw();
    test_store_narrow();
    test_loads();
    test_ready_outside();
    test_timeout();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
